// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM stage register with a valid/ready handshake, a 2-entry skid buffer and flush.
// Reusable for ID/EX and MEM/WB by changing the parameters.
module ex_mem_pipe_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 32,
  parameter int N_DATA = 2,
  parameter int RW_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [N_DATA*DATA_W-1:0] in_data,
  input  logic [RW_W-1:0]          in_rw,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [N_DATA*DATA_W-1:0] out_data,
  output logic [RW_W-1:0]          out_rw,
  output logic [1:0]               occupancy
);

  localparam int D_W = N_DATA * DATA_W;
  localparam int E_W = CTRL_W + D_W + RW_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [E_W-1:0] main_q;
  logic [E_W-1:0] skid_q;
  logic [E_W-1:0] in_ent;
  logic           accept;
  logic           drain;

  assign in_ent = {in_ctrl, in_data, in_rw};
  // An entry offered during a flush is squashed, never accepted.
  assign accept = in_valid & in_ready & ~flush;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state_n = ONE;
        ONE: begin
          if (accept && !drain)      state_n = TWO;
          else if (!accept && drain) state_n = EMPTY;
        end
        TWO:     if (drain) state_n = ONE;
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      unique case (state)
        EMPTY: if (accept) main_q <= in_ent;
        ONE: begin
          if (accept && drain) main_q <= in_ent;
          else if (accept)     skid_q <= in_ent;
        end
        TWO:     if (drain) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  // Bubbles present zero ctrl/rw so the next stage never acts on them.
  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
    occupancy = state;
    out_data  = main_q[RW_W +: D_W];
    out_ctrl  = out_valid ? main_q[E_W-1 -: CTRL_W] : '0;
    out_rw    = out_valid ? main_q[RW_W-1:0] : '0;
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed and random checks of ex_mem_pipe_reg against a queue-based FIFO model.
// Every comparison is an immediate assertion.
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic [3:0]  c;
    logic [63:0] d;
    logic [4:0]  r;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [63:0] in_data;
  logic [4:0]  in_rw;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ctrl;
  logic [63:0] out_data;
  logic [4:0]  out_rw;
  logic [1:0]  occupancy;

  int   n_assert = 0;
  int   n_fail   = 0;
  ent_t q[$];
  bit   rst_last = 0;

  ex_mem_pipe_reg #(
    .CTRL_W(4),
    .DATA_W(32),
    .N_DATA(2),
    .RW_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .in_rw(in_rw),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .out_rw(out_rw),
    .occupancy(occupancy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(ent_t e);
    in_ctrl = e.c;
    in_data = e.d;
    in_rw   = e.r;
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.c = 4'($urandom);
    e.d = {$urandom, $urandom};
    e.r = 5'($urandom);
    return e;
  endfunction

  task automatic check_all(string ph);
    int n;
    n = q.size();
    chk({ph, ".out_valid"}, 64'(out_valid), 64'(n > 0));
    chk({ph, ".occupancy"}, 64'(occupancy), 64'(n));
    chk({ph, ".in_ready"}, 64'(in_ready), 64'(n < 2));
    if (n > 0) begin
      chk({ph, ".out_ctrl"}, 64'(out_ctrl), 64'(q[0].c));
      chk({ph, ".out_data"}, out_data, q[0].d);
      chk({ph, ".out_rw"}, 64'(out_rw), 64'(q[0].r));
    end else begin
      chk({ph, ".bub_ctrl"}, 64'(out_ctrl), 64'(0));
      chk({ph, ".bub_rw"}, 64'(out_rw), 64'(0));
      if (rst_last) chk({ph, ".rst_data"}, out_data, 64'(0));
    end
  endtask

  // One clock: update the FIFO model from the driven inputs, then check.
  task automatic step(string ph);
    bit   acc;
    bit   drn;
    ent_t cur;
    @(posedge clk);
    cur = '{c: in_ctrl, d: in_data, r: in_rw};
    if (reset) begin
      q.delete();
      rst_last = 1;
    end else begin
      rst_last = 0;
      if (flush) begin
        q.delete();
      end else begin
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(cur);
      end
    end
    #1;
    check_all(ph);
  endtask

  initial begin
    ent_t a;
    reset     = 1;
    flush     = 0;
    in_valid  = 1;
    out_ready = 0;
    put(rnd_ent());

    step("reset");
    step("reset");

    reset     = 0;
    out_ready = 1;
    a = '{c: 4'hA, d: 64'h00000005_00001234, r: 5'd7};
    put(a);
    step("pass");
    chk("pass.exact_data", out_data, 64'h00000005_00001234);
    chk("pass.exact_ctrl", 64'(out_ctrl), 64'hA);
    for (int i = 0; i < 8; i++) begin
      put(rnd_ent());
      step("stream");
      chk("stream.occ1", 64'(occupancy), 64'd1);
    end
    in_valid = 0;
    step("stream_end");

    out_ready = 0;
    in_valid  = 1;
    put(rnd_ent());
    step("bp_a");
    put(rnd_ent());
    step("bp_b");
    put(rnd_ent());
    step("bp_c_held");
    step("bp_c_held");
    out_ready = 1;
    step("bp_drain_a");
    step("bp_drain_b");
    in_valid = 0;
    step("bp_drain_c");
    step("bp_empty");

    out_ready = 0;
    in_valid  = 1;
    put(rnd_ent());
    step("fl_fill");
    put(rnd_ent());
    step("fl_fill");
    flush = 1;
    put(rnd_ent());
    step("flush");
    flush     = 0;
    in_valid  = 0;
    out_ready = 1;
    step("flush_after");

    in_valid = 1;
    put(rnd_ent());
    step("one_d");
    put(rnd_ent());
    step("one_e");
    in_valid = 0;
    step("one_end");

    out_ready = 0;
    in_valid  = 1;
    put(rnd_ent());
    step("rf_fill");
    put(rnd_ent());
    step("rf_fill");
    reset = 1;
    flush = 1;
    step("rst_flush");
    reset     = 0;
    flush     = 0;
    out_ready = 1;
    put(rnd_ent());
    step("rst_first");
    in_valid = 0;
    step("rst_end");

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 60) == 0);
      put(rnd_ent());
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
